// File: rtl/button_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg : shared defaults, button index constants and width helper for
//              the button_debounce slice.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package button_pkg;

  localparam int unsigned DEF_CLK_DIV        = 1200;
  localparam int unsigned DEF_DEBOUNCE_TICKS = 50;
  localparam int unsigned DEF_LONG_TICKS     = 5000;
  localparam bit          DEF_ACTIVE_LOW     = 1'b1;

  localparam int unsigned BTN_UP    = 0;
  localparam int unsigned BTN_DOWN  = 1;
  localparam int unsigned BTN_LEFT  = 2;
  localparam int unsigned BTN_RIGHT = 3;

  // Counter width able to hold the value n itself.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 1) ? 1 : $clog2(n + 1);
  endfunction

endpackage

`default_nettype wire

// File: rtl/debounce_chan.sv
// ---------------------------------------------------------------------------
// debounce_chan : one debounced button channel with press/release pulses and
//                 optional hold detection (enabled by `LONG_PRESS_EN).
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module debounce_chan
  import button_pkg::*;
#(
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int unsigned LONG_TICKS     = DEF_LONG_TICKS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic raw_i,
  input  logic tick_i,
  output logic state_o,
  output logic pressed_o,
  output logic released_o,
  output logic long_press_o
);

  localparam int unsigned             c_CNT_W    = cnt_width(DEBOUNCE_TICKS);
  localparam logic [c_CNT_W-1:0]      c_CNT_LAST = c_CNT_W'(DEBOUNCE_TICKS - 1);

  if (DEBOUNCE_TICKS < 1 || LONG_TICKS < 1) begin : g_bad_params
    $fatal(1, "debounce_chan: DEBOUNCE_TICKS and LONG_TICKS must be >= 1");
  end

  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic               state_q, state_d;
  logic               pressed_q, pressed_d;
  logic               released_q, released_d;

  always_comb begin
    cnt_d      = cnt_q;
    state_d    = state_q;
    pressed_d  = 1'b0;
    released_d = 1'b0;
    // Any return to the accepted level throws away the partial count.
    if (raw_i == state_q) begin
      cnt_d = '0;
    end else if (tick_i) begin
      if (cnt_q == c_CNT_LAST) begin
        cnt_d      = '0;
        state_d    = raw_i;
        pressed_d  = raw_i;
        released_d = ~raw_i;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      state_q    <= 1'b0;
      pressed_q  <= 1'b0;
      released_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      state_q    <= state_d;
      pressed_q  <= pressed_d;
      released_q <= released_d;
    end
  end

  assign state_o    = state_q;
  assign pressed_o  = pressed_q;
  assign released_o = released_q;

`ifdef LONG_PRESS_EN
  localparam int unsigned        c_HOLD_W    = cnt_width(LONG_TICKS);
  localparam logic [c_HOLD_W-1:0] c_HOLD_MAX = c_HOLD_W'(LONG_TICKS);

  logic [c_HOLD_W-1:0] hold_q, hold_d;
  logic                long_q, long_d;

  always_comb begin
    hold_d = hold_q;
    long_d = 1'b0;
    if (!state_q) begin
      hold_d = '0;
    end else if (tick_i && (hold_q != c_HOLD_MAX)) begin
      hold_d = hold_q + 1'b1;
      long_d = (hold_d == c_HOLD_MAX);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hold_q <= '0;
      long_q <= 1'b0;
    end else begin
      hold_q <= hold_d;
      long_q <= long_d;
    end
  end

  assign long_press_o = long_q;
`else
  assign long_press_o = 1'b0;
`endif

endmodule

`default_nettype wire

// File: rtl/button_debounce.sv
// ---------------------------------------------------------------------------
// button_debounce : shared sample prescaler feeding WIDTH debounce channels.
//                   Optional hold detection via `LONG_PRESS_EN.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module button_debounce
  import button_pkg::*;
#(
  parameter int unsigned WIDTH          = 4,
  parameter int unsigned CLK_DIV        = DEF_CLK_DIV,
  parameter int unsigned DEBOUNCE_TICKS = DEF_DEBOUNCE_TICKS,
  parameter int unsigned LONG_TICKS     = DEF_LONG_TICKS,
  parameter bit          ACTIVE_LOW     = DEF_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] in_i,
  output logic [WIDTH-1:0] state_o,
  output logic [WIDTH-1:0] pressed_o,
  output logic [WIDTH-1:0] released_o,
  output logic [WIDTH-1:0] long_press_o
);

  localparam int unsigned         c_DIV_W    = cnt_width(CLK_DIV - 1);
  localparam logic [c_DIV_W-1:0]  c_DIV_LAST = c_DIV_W'(CLK_DIV - 1);

  if (CLK_DIV < 2) begin : g_bad_div
    $fatal(1, "button_debounce: CLK_DIV must be >= 2");
  end

  logic [c_DIV_W-1:0] presc_q, presc_d;
  logic               w_tick;
  logic [WIDTH-1:0]   w_raw;

  assign w_tick  = (presc_q == c_DIV_LAST);
  assign presc_d = w_tick ? '0 : presc_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // Normalise polarity so every channel sees 1 = pressed.
  assign w_raw = in_i ^ {WIDTH{ACTIVE_LOW}};

  for (genvar g = 0; g < WIDTH; g++) begin : g_chan
    debounce_chan #(
      .DEBOUNCE_TICKS (DEBOUNCE_TICKS),
      .LONG_TICKS     (LONG_TICKS)
    ) u_chan (
      .clk          (clk),
      .rst_n        (rst_n),
      .raw_i        (w_raw[g]),
      .tick_i       (w_tick),
      .state_o      (state_o[g]),
      .pressed_o    (pressed_o[g]),
      .released_o   (released_o[g]),
      .long_press_o (long_press_o[g])
    );
  end

endmodule

`default_nettype wire

// File: tb/tb_button_debounce.sv
// ---------------------------------------------------------------------------
// tb_button_debounce : directed and random stimulus against a tick-count
//                      reference model of the debouncer.
// Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_button_debounce;

  localparam int W    = 4;
  localparam int DIV  = 4;
  localparam int DEB  = 3;
  localparam int LONG = 5;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic [W-1:0] in_drv = '1;
  logic [W-1:0] state_o, pressed_o, released_o, long_press_o;

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model: cycles since reset, and per channel the accepted level,
  // number of ticks the input has disagreed with it, and ticks held pressed.
  int           m_cyc;
  logic [W-1:0] m_state;
  int           m_run  [W];
  int           m_hold [W];
  logic [W-1:0] e_pr, e_rl, e_lp;

  button_debounce #(
    .WIDTH          (W),
    .CLK_DIV        (DIV),
    .DEBOUNCE_TICKS (DEB),
    .LONG_TICKS     (LONG),
    .ACTIVE_LOW     (1'b1)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_i         (in_drv),
    .state_o      (state_o),
    .pressed_o    (pressed_o),
    .released_o   (released_o),
    .long_press_o (long_press_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_i(input string tag, input int obs, input int exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_edge(input logic rn, input logic [W-1:0] inv);
    logic tick;
    logic prev;
    e_pr = '0; e_rl = '0; e_lp = '0;
    if (!rn) begin
      m_cyc = 0; m_state = '0;
      for (int i = 0; i < W; i++) begin m_run[i] = 0; m_hold[i] = 0; end
      return;
    end
    m_cyc++;
    tick = (m_cyc % DIV) == 0;
    for (int i = 0; i < W; i++) begin
      prev = m_state[i];
      if (!inv[i] == m_state[i]) m_run[i] = 0;
      else if (tick) begin
        m_run[i]++;
        if (m_run[i] == DEB) begin
          m_state[i] = !inv[i];
          m_run[i] = 0;
          e_pr[i] = m_state[i];
          e_rl[i] = !m_state[i];
        end
      end
`ifdef LONG_PRESS_EN
      if (!prev) m_hold[i] = 0;
      else if (tick && m_hold[i] < LONG) begin
        m_hold[i]++;
        if (m_hold[i] == LONG) e_lp[i] = 1'b1;
      end
`else
      if (prev) m_hold[i] = 0;
`endif
    end
  endtask

  // One clock: apply inputs, advance the model, compare away from the edge.
  task automatic step(input logic [W-1:0] inv, input logic rn);
    in_drv = inv;
    rst_n  = rn;
    @(posedge clk);
    model_edge(rn, inv);
    #1;
    chk("state", state_o, m_state);
    chk("pressed", pressed_o, e_pr);
    chk("released", released_o, e_rl);
    chk("long_press", long_press_o, e_lp);
    chk("pr_rl_excl", pressed_o & released_o, '0);
  endtask

  initial begin
    int first, npr, d, lastlow, nlp;
    logic both;
    logic [W-1:0] v;
    int len;

    // Reset state
    step(4'hF, 1'b0);
    step(4'hF, 1'b0);
    chk("reset_state", state_o, 4'h0);

    // 1: ch0 held pressed from reset release -> press on cycle 12
    first = 0; npr = 0;
    for (int k = 1; k <= 20; k++) begin
      step(4'hE, 1'b1);
      if (pressed_o[0]) begin npr++; if (first == 0) first = k; end
    end
    chk_i("t1_press_cycle", first, 12);
    chk_i("t1_press_count", npr, 1);
    chk("t1_state", state_o, 4'h1);

    // 2: bounce on ch1
    npr = 0; lastlow = 0; d = 0;
    for (int k = 0; k < 6; k++) begin step(4'hC, 1'b1); if (pressed_o[1]) npr++; end
    step(4'hE, 1'b1); if (pressed_o[1]) npr++;
    for (int k = 1; k <= 30; k++) begin
      step(4'hC, 1'b1);
      if (pressed_o[1]) begin npr++; if (d == 0) d = k; end
    end
    chk_i("t2_press_count", npr, 1);
    chk_i("t2_delay_in_window", int'(d >= 9 && d <= 12), 1);

    // 3: release ch0
    npr = 0;
    for (int k = 0; k < 20; k++) begin step(4'hD, 1'b1); if (released_o[0]) npr++; end
    chk_i("t3_release_count", npr, 1);
    chk("t3_state", state_o, 4'h2);

    // 4: ch2, ch3 fall together; also holds long enough for long_press
    both = 1'b0; nlp = 0;
    for (int k = 0; k < 50; k++) begin
      step(4'h1, 1'b1);
      if (pressed_o[2] && pressed_o[3]) both = 1'b1;
      if (long_press_o[2]) nlp++;
    end
    chk_i("t4_simultaneous", int'(both), 1);
`ifdef LONG_PRESS_EN
    chk_i("t6_long_count", nlp, 1);
`else
    chk_i("t6_long_count", nlp, 0);
`endif

    // 5: reset in the middle of a debounce
    step(4'hF, 1'b0);
    step(4'hF, 1'b1);
    step(4'hF, 1'b1);
    npr = 0;
    for (int k = 0; k < 8; k++) begin step(4'hE, 1'b1); if (pressed_o[0]) npr++; end
    step(4'hE, 1'b0);
    chk_i("t5_no_event", npr, 0);
    first = 0;
    for (int k = 1; k <= 20; k++) begin
      step(4'hE, 1'b1);
      if (pressed_o[0] && first == 0) first = k;
    end
    chk_i("t5_press_cycle", first, 12);

    // Random segments with occasional resets
    for (int s = 0; s < 300; s++) begin
      v   = W'($urandom);
      len = $urandom_range(1, 16);
      for (int k = 0; k < len; k++) step(v, ($urandom_range(0, 199) != 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
